// File: rtl/rx_stream_arbiter_pkg.sv
// Shared types and constants for the RX stream arbiter: FSM encoding,
// channel indices and word/byte geometry.
package rx_stream_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        PULL  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } arb_state_t;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rx_stream_arbiter_if.sv
// FIFO read sides (09 and 24) plus the serialised byte stream towards smi_ctrl.
// master = arbiter side, slave = FIFOs and byte consumer.
interface rx_stream_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              o_fifo_09_pull;
    logic [DATA_W-1:0] i_fifo_09_data;
    logic              i_fifo_09_empty;
    logic              i_fifo_09_full;

    logic              o_fifo_24_pull;
    logic [DATA_W-1:0] i_fifo_24_data;
    logic              i_fifo_24_empty;
    logic              i_fifo_24_full;

    logic              o_byte_valid;
    logic              i_byte_ready;
    logic [7:0]        o_byte_data;
    logic              o_byte_channel;
    logic              o_byte_sow;

    modport master (
        output o_fifo_09_pull, o_fifo_24_pull,
        input  i_fifo_09_data, i_fifo_09_empty, i_fifo_09_full,
        input  i_fifo_24_data, i_fifo_24_empty, i_fifo_24_full,
        output o_byte_valid, o_byte_data, o_byte_channel, o_byte_sow,
        input  i_byte_ready
    );

    modport slave (
        input  o_fifo_09_pull, o_fifo_24_pull,
        output i_fifo_09_data, i_fifo_09_empty, i_fifo_09_full,
        output i_fifo_24_data, i_fifo_24_empty, i_fifo_24_full,
        input  o_byte_valid, o_byte_data, o_byte_channel, o_byte_sow,
        output i_byte_ready
    );

endinterface

// File: rtl/rx_stream_arbiter_word_serializer.sv
// Latches one FIFO word and emits it MSB-first as valid/ready bytes; byte 0 valid the
// cycle after load; holds data/channel/sow while ready is low; done pulses on the last accept.
module word_serializer
    import rx_stream_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    input  logic              ch,
    input  logic              ready,
    output logic              valid,
    output logic [7:0]        data,
    output logic              channel,
    output logic              sow,
    output logic              done
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    // The top byte of the shift register is always the byte on the wire.
    assign data = shreg[DATA_W-1 -: 8];
    assign sow  = valid & (idx == '0);
    assign done = valid & ready & (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            channel <= 1'b0;
        end else if (load) begin
            shreg   <= word;
            idx     <= '0;
            valid   <= 1'b1;
            channel <= ch;
        end else if (valid && ready) begin
            if (idx == LAST_IDX) begin
                valid <= 1'b0;
            end else begin
                idx   <= idx + 1'b1;
                shreg <= shreg << 8;
            end
        end
    end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Round-robin arbiter sharing the SMI read path between the 09 and 24 RX FIFOs.
// First byte 3 cycles after a grant decision; a stalled byte holds, no new pull until the word is sent.
module rx_stream_arbiter
    import rx_stream_pkg::*;
#(
    parameter int BURST_WORDS = 4,
    parameter int DATA_W      = 32
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_ch_enable,
    input  logic                 i_clear_status,
    rx_stream_arbiter_if.master  bus,
    output logic [1:0]           o_overflow,
    output logic                 o_busy
);

    localparam logic [7:0] BURST_LIM = 8'(BURST_WORDS);

    arb_state_t        state;
    logic              cur_ch;
    logic              cur_vld;
    logic [7:0]        burst_cnt;
    logic              pull_09;
    logic              pull_24;

    logic [1:0]        elig;
    logic              grant;
    logic              next_ch;
    logic              clr_burst;
    logic [DATA_W-1:0] sel_data;
    logic              ser_done;

    assign elig     = i_ch_enable & ~{bus.i_fifo_24_empty, bus.i_fifo_09_empty};
    assign sel_data = (cur_ch == CH_24) ? bus.i_fifo_24_data : bus.i_fifo_09_data;

    assign bus.o_fifo_09_pull = pull_09;
    assign bus.o_fifo_24_pull = pull_24;

    // cur_vld is clear until the first grant, so the reset-time "last = 24"
    // never counts as an active burst and 09 wins the first tie.
    always_comb begin
        grant     = 1'b0;
        next_ch   = cur_ch;
        clr_burst = 1'b0;
        if (cur_vld && elig[cur_ch] && (burst_cnt < BURST_LIM)) begin
            grant = 1'b1;
        end else if (elig[~cur_ch]) begin
            grant     = 1'b1;
            next_ch   = ~cur_ch;
            clr_burst = 1'b1;
        end else if (elig[cur_ch]) begin
            grant     = 1'b1;
            clr_burst = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state     <= ARB;
            cur_ch    <= CH_24;
            cur_vld   <= 1'b0;
            burst_cnt <= 8'd0;
            pull_09   <= 1'b0;
            pull_24   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (grant) begin
                        cur_ch  <= next_ch;
                        cur_vld <= 1'b1;
                        if (clr_burst) begin
                            burst_cnt <= 8'd0;
                        end
                        pull_09 <= (next_ch == CH_09);
                        pull_24 <= (next_ch == CH_24);
                        o_busy  <= 1'b1;
                        state   <= PULL;
                    end
                end
                PULL: begin
                    pull_09 <= 1'b0;
                    pull_24 <= 1'b0;
                    state   <= LATCH;
                end
                LATCH: begin
                    if (burst_cnt != 8'hFF) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    state <= SEND;
                end
                SEND: begin
                    if (ser_done) begin
                        o_busy <= 1'b0;
                        state  <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Set has priority over a coincident clear so no overflow event is lost.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            o_overflow <= 2'b00;
        end else begin
            o_overflow <= (o_overflow & ~{2{i_clear_status}})
                        | ({bus.i_fifo_24_full, bus.i_fifo_09_full} & i_ch_enable);
        end
    end

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_word_serializer (
        .clk     (i_sys_clk),
        .rst     (i_reset),
        .load    (state == LATCH),
        .word    (sel_data),
        .ch      (cur_ch),
        .ready   (bus.i_byte_ready),
        .valid   (bus.o_byte_valid),
        .data    (bus.o_byte_data),
        .channel (bus.o_byte_channel),
        .sow     (bus.o_byte_sow),
        .done    (ser_done)
    );

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Bench for rx_stream_arbiter: two instances (burst 1 and burst 4) fed by queue-based FIFO
// models; accepted bytes are compared against a transaction-level arbitration model.
module tb_rx_stream_arbiter;
    import rx_stream_pkg::*;

    typedef struct packed {
        logic       ch;
        logic       sow;
        logic [7:0] dat;
    } bw_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic       clr;
    logic [1:0] ovf_a, ovf_b;
    logic       busy_a, busy_b;

    always #5 clk = ~clk;

    rx_stream_arbiter_if #(.DATA_W(32)) ifa ();
    rx_stream_arbiter_if #(.DATA_W(32)) ifb ();

    rx_stream_arbiter #(.BURST_WORDS(1), .DATA_W(32)) u_dut_a (
        .i_sys_clk(clk), .i_reset(rst), .i_ch_enable(en), .i_clear_status(clr),
        .bus(ifa), .o_overflow(ovf_a), .o_busy(busy_a)
    );

    rx_stream_arbiter #(.BURST_WORDS(4), .DATA_W(32)) u_dut_b (
        .i_sys_clk(clk), .i_reset(rst), .i_ch_enable(en), .i_clear_status(clr),
        .bus(ifb), .o_overflow(ovf_b), .o_busy(busy_b)
    );

    logic [31:0] q09a[$], q24a[$], q09b[$], q24b[$];
    logic [31:0] s09[$], s24[$];
    bw_t         obs_a[$], obs_b[$], exp_q[$];

    int  n_cmp = 0, n_bad = 0;
    int  viol = 0, stall_err = 0, pull_cnt_a = 0;
    bit  pv_a, pr_a, pv_b, pr_b;
    bw_t pb_a, pb_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_empty();
        ifa.i_fifo_09_empty = (q09a.size() == 0);
        ifa.i_fifo_24_empty = (q24a.size() == 0);
        ifb.i_fifo_09_empty = (q09b.size() == 0);
        ifb.i_fifo_24_empty = (q24b.size() == 0);
    endtask

    task automatic push(input int sel, input logic ch, input logic [31:0] w);
        if (sel == 0) begin
            if (ch) q24a.push_back(w); else q09a.push_back(w);
        end else begin
            if (ch) q24b.push_back(w); else q09b.push_back(w);
        end
        if (ch) s24.push_back(w); else s09.push_back(w);
        upd_empty();
    endtask

    // One clock: observe at the falling edge, serve FIFO reads just after the rising edge.
    task automatic step();
        bw_t ca, cb;
        bit  p09a, p24a, p09b, p24b;
        @(negedge clk);
        ca = {ifa.o_byte_channel, ifa.o_byte_sow, ifa.o_byte_data};
        cb = {ifb.o_byte_channel, ifb.o_byte_sow, ifb.o_byte_data};
        if (!rst) begin
            if (pv_a && !pr_a && !(ifa.o_byte_valid && ca == pb_a)) stall_err++;
            if (pv_b && !pr_b && !(ifb.o_byte_valid && cb == pb_b)) stall_err++;
            if (ifa.o_byte_valid && ifa.i_byte_ready) obs_a.push_back(ca);
            if (ifb.o_byte_valid && ifb.i_byte_ready) obs_b.push_back(cb);
            if (ifa.o_fifo_09_pull && ifa.o_fifo_24_pull) viol++;
            if (ifb.o_fifo_09_pull && ifb.o_fifo_24_pull) viol++;
            if ((ifa.o_fifo_09_pull || ifa.o_fifo_24_pull) && ifa.o_byte_valid) viol++;
            if ((ifb.o_fifo_09_pull || ifb.o_fifo_24_pull) && ifb.o_byte_valid) viol++;
            pull_cnt_a += int'(ifa.o_fifo_09_pull) + int'(ifa.o_fifo_24_pull);
        end
        pv_a = ifa.o_byte_valid && !rst;  pr_a = ifa.i_byte_ready;  pb_a = ca;
        pv_b = ifb.o_byte_valid && !rst;  pr_b = ifb.i_byte_ready;  pb_b = cb;
        p09a = ifa.o_fifo_09_pull && !rst;  p24a = ifa.o_fifo_24_pull && !rst;
        p09b = ifb.o_fifo_09_pull && !rst;  p24b = ifb.o_fifo_24_pull && !rst;
        @(posedge clk);
        #1;
        if (p09a) begin if (q09a.size() == 0) viol++; else ifa.i_fifo_09_data = q09a.pop_front(); end
        if (p24a) begin if (q24a.size() == 0) viol++; else ifa.i_fifo_24_data = q24a.pop_front(); end
        if (p09b) begin if (q09b.size() == 0) viol++; else ifb.i_fifo_09_data = q09b.pop_front(); end
        if (p24b) begin if (q24b.size() == 0) viol++; else ifb.i_fifo_24_data = q24b.pop_front(); end
        upd_empty();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        q09a.delete(); q24a.delete(); q09b.delete(); q24b.delete();
        s09.delete(); s24.delete();
        ifa.i_fifo_09_full = 1'b0; ifa.i_fifo_24_full = 1'b0;
        ifb.i_fifo_09_full = 1'b0; ifb.i_fifo_24_full = 1'b0;
        ifa.i_byte_ready = 1'b1; ifb.i_byte_ready = 1'b1;
        upd_empty();
        step();
        step();
        rst = 1'b0;
        obs_a.delete(); obs_b.delete();
    endtask

    // Transaction-level reference: replay the round-robin/burst rules over the queued words.
    task automatic build_exp(input int burst);
        logic [31:0] m09[$], m24[$];
        logic [31:0] w;
        int last, used, ch;
        bit ec, eo;
        m09 = s09; m24 = s24;
        last = 1; used = burst;
        exp_q.delete();
        while (m09.size() + m24.size() > 0) begin
            ec = (last == 1) ? (m24.size() > 0) : (m09.size() > 0);
            eo = (last == 1) ? (m09.size() > 0) : (m24.size() > 0);
            if (ec && used < burst) ch = last;
            else if (eo) begin ch = 1 - last; used = 0; end
            else begin ch = last; used = 0; end
            w = (ch == 1) ? m24.pop_front() : m09.pop_front();
            used++;
            last = ch;
            for (int b = 0; b < 4; b++) exp_q.push_back({1'(ch), (b == 0), w[31-8*b -: 8]});
        end
    endtask

    task automatic cmp_stream(input string tag, input int sel);
        bw_t o[$];
        int  n;
        o = (sel == 0) ? obs_a : obs_b;
        chk({tag, "_len"}, 64'(o.size()), 64'(exp_q.size()));
        n = (o.size() < exp_q.size()) ? o.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, 64'(o[i]), 64'(exp_q[i]));
    endtask

    task automatic wait_idle(input int sel, input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            if (rnd) begin
                if (sel == 0) ifa.i_byte_ready = ($urandom_range(0, 3) != 0);
                else          ifb.i_byte_ready = ($urandom_range(0, 3) != 0);
            end
            step();
            if (sel == 0) done = (q09a.size() == 0) && (q24a.size() == 0) && !busy_a && !ifa.o_byte_valid;
            else          done = (q09b.size() == 0) && (q24b.size() == 0) && !busy_b && !ifb.o_byte_valid;
        end
        ifa.i_byte_ready = 1'b1;
        ifb.i_byte_ready = 1'b1;
        chk("idle_reached", 64'(done), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit found;
        int pulls0;
        en = 2'b11;
        rst = 1'b1;
        clr = 1'b0;
        ifa.i_fifo_09_data = '0; ifa.i_fifo_24_data = '0;
        ifb.i_fifo_09_data = '0; ifb.i_fifo_24_data = '0;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(ifa.o_byte_valid), 64'd0);
        chk("rst_sow", 64'(ifa.o_byte_sow), 64'd0);
        chk("rst_pulls", 64'({ifa.o_fifo_24_pull, ifa.o_fifo_09_pull}), 64'd0);
        chk("rst_busy", 64'({busy_b, busy_a}), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);

        // T1: burst 1 alternation and first-byte latency
        push(0, 1'b0, 32'h11223344); push(0, 1'b0, 32'h55667788);
        push(0, 1'b1, 32'hAABBCCDD); push(0, 1'b1, 32'hEEFF0011);
        step(); step();
        chk("t1_lat_early", 64'(ifa.o_byte_valid), 64'd0);
        step();
        chk("t1_lat_valid", 64'(ifa.o_byte_valid), 64'd1);
        chk("t1_first_byte", 64'({ifa.o_byte_channel, ifa.o_byte_sow, ifa.o_byte_data}), 64'({1'b0, 1'b1, 8'h11}));
        wait_idle(0, 1'b0);
        build_exp(1);
        cmp_stream("t1_stream", 0);

        // T2: burst 4 on the second instance
        do_reset();
        for (int k = 1; k <= 6; k++) push(1, 1'b0, 32'h09000000 + 32'(k));
        push(1, 1'b1, 32'h24000001);
        wait_idle(1, 1'b0);
        build_exp(4);
        cmp_stream("t2_burst4", 1);

        // T3: ready low for 5 cycles on byte 2
        do_reset();
        push(0, 1'b0, 32'hCAFEBABE);
        push(0, 1'b1, 32'h12345678);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = ifa.o_byte_valid && (ifa.o_byte_data == 8'hBA);
        end
        chk("t3_found_ba", 64'(found), 64'd1);
        ifa.i_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold", 64'({ifa.o_byte_valid, ifa.o_byte_channel, ifa.o_byte_sow, ifa.o_byte_data}),
                64'({1'b1, 1'b0, 1'b0, 8'hBA}));
            chk("t3_no_pull", 64'({ifa.o_fifo_24_pull, ifa.o_fifo_09_pull}), 64'd0);
        end
        ifa.i_byte_ready = 1'b1;
        wait_idle(0, 1'b0);
        build_exp(1);
        cmp_stream("t3_stream", 0);

        // T4: enables dropped during byte 1
        do_reset();
        push(0, 1'b0, 32'h01020304);
        push(0, 1'b1, 32'h0A0B0C0D);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = ifa.o_byte_valid && !ifa.o_byte_sow;
        end
        chk("t4_found_b1", 64'(found), 64'd1);
        en = 2'b00;
        pulls0 = pull_cnt_a;
        for (int i = 0; i < 30; i++) step();
        chk("t4_no_pulls", 64'(pull_cnt_a - pulls0), 64'd0);
        chk("t4_idle", 64'({busy_a, ifa.o_byte_valid}), 64'd0);
        s24.delete();
        build_exp(1);
        cmp_stream("t4_stream", 0);
        en = 2'b11;

        // T5: overflow set/clear priority
        do_reset();
        ifa.i_fifo_24_full = 1'b1;
        step();
        ifa.i_fifo_24_full = 1'b0;
        chk("t5_set", 64'(ovf_a), 64'b10);
        clr = 1'b1; ifa.i_fifo_24_full = 1'b1;
        step();
        clr = 1'b0; ifa.i_fifo_24_full = 1'b0;
        chk("t5_set_wins", 64'(ovf_a), 64'b10);
        step();
        chk("t5_sticky", 64'(ovf_a), 64'b10);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t5_cleared", 64'(ovf_a), 64'b00);
        en = 2'b01; ifa.i_fifo_24_full = 1'b1;
        step();
        chk("t5_disabled", 64'(ovf_a), 64'b00);
        ifa.i_fifo_24_full = 1'b0; ifa.i_fifo_09_full = 1'b1;
        step();
        ifa.i_fifo_09_full = 1'b0;
        chk("t5_ch09", 64'(ovf_a), 64'b01);
        en = 2'b11;

        // T6: reset during byte 1
        do_reset();
        push(0, 1'b0, 32'hDEADBEEF);
        push(0, 1'b1, 32'h0BADF00D);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = ifa.o_byte_valid && !ifa.o_byte_sow;
        end
        chk("t6_found_b1", 64'(found), 64'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_byte", 64'({ifa.o_byte_valid, ifa.o_byte_channel, ifa.o_byte_sow, ifa.o_byte_data}), 64'd0);
        chk("t6_rst_ctl", 64'({busy_a, ovf_a, ifa.o_fifo_24_pull, ifa.o_fifo_09_pull}), 64'd0);
        s09.delete(); s24.delete();
        s24.push_back(32'h0BADF00D);
        push(0, 1'b0, 32'h600DCAFE);
        obs_a.delete();
        rst = 1'b0;
        wait_idle(0, 1'b0);
        build_exp(1);
        cmp_stream("t6_after_rst", 0);

        // Randomised word counts, payloads and ready back-pressure
        for (int r = 0; r < 6; r++) begin
            int sel, n0, n1;
            sel = r % 2;
            n0 = $urandom_range(0, 6);
            n1 = $urandom_range(0, 6);
            do_reset();
            for (int k = 0; k < n0; k++) push(sel, 1'b0, $urandom());
            for (int k = 0; k < n1; k++) push(sel, 1'b1, $urandom());
            wait_idle(sel, 1'b1);
            build_exp((sel == 0) ? 1 : 4);
            cmp_stream("rand_stream", sel);
        end

        chk("pull_protocol", 64'(viol), 64'd0);
        chk("stall_hold", 64'(stall_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
